// File: rtl/diff_scan_ctrl.sv
// Multi-cycle diff-scan sequencer: latches an operand pair and streams every
// differing bit position (LSB first) on a valid/ready port, then reports a count.
module diff_scan_ctrl #(
    parameter int WIDTH    = 32,
    parameter int POSW     = 6,
    parameter int MAX_HITS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             pos_valid,
    input  logic             pos_ready,
    output logic [POSW-1:0]  pos,
    output logic             done,
    output logic [POSW-1:0]  count
);

    localparam int IDXW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] diff_x;
    logic [POSW-1:0]  diff_pos;
    logic             diff_eq;
    logic             load;
    logic             present;
    logic             accept;

    // Saturating increment: count stops at MAX_HITS and never wraps.
    function automatic logic [POSW-1:0] sat_inc(input logic [POSW-1:0] c);
        if (c >= POSW'(MAX_HITS)) begin
            return c;
        end
        return c + POSW'(1);
    endfunction

    // Combinational diff unit, fed only from the latched operands.
    assign diff_x  = a_reg ^ b_reg;
    assign diff_eq = (diff_x == '0);

    always_comb begin
        diff_pos = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (diff_x[i]) begin
                diff_pos = POSW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        present   = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (diff_eq || (count == POSW'(MAX_HITS))) begin
                    state_nxt = FIN;
                end else begin
                    present   = 1'b1;
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (pos_valid && pos_ready) begin
                    accept    = 1'b1;
                    state_nxt = SCAN;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Clearing the accepted difference in b_reg lets the next SCAN find the next-higher bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            pos       <= '0;
            pos_valid <= 1'b0;
            count     <= '0;
        end else begin
            if (load) begin
                a_reg <= a_in;
                b_reg <= b_in;
                count <= '0;
            end
            if (present) begin
                pos       <= diff_pos;
                pos_valid <= 1'b1;
            end
            if (accept) begin
                b_reg[pos[IDXW-1:0]] <= a_reg[pos[IDXW-1:0]];
                count                <= sat_inc(count);
                pos_valid            <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == FIN);

endmodule

// File: tb/tb_diff_scan_ctrl.sv
// Scoreboard bench for diff_scan_ctrl: two instances (MAX_HITS 32 and 4) share stimulus;
// expected beats come from a bit-list model of the operand difference.
module tb_diff_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        pos_ready;
    logic [1:0]  busy_w;
    logic [1:0]  pv_w;
    logic [1:0]  done_w;
    logic [5:0]  pos_w [2];
    logic [5:0]  cnt_w [2];

    int n_chk;
    int n_pass;
    int exp_pos_q0[$];
    int exp_pos_q1[$];
    int exp_cnt_q0[$];
    int exp_cnt_q1[$];
    int mh [2];
    logic [1:0] held;
    int held_pos [2];

    diff_scan_ctrl #(.WIDTH(32), .POSW(6), .MAX_HITS(32)) u0 (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
        .busy(busy_w[0]), .pos_valid(pv_w[0]), .pos_ready(pos_ready),
        .pos(pos_w[0]), .done(done_w[0]), .count(cnt_w[0])
    );

    diff_scan_ctrl #(.WIDTH(32), .POSW(6), .MAX_HITS(4)) u1 (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
        .busy(busy_w[1]), .pos_valid(pv_w[1]), .pos_ready(pos_ready),
        .pos(pos_w[1]), .done(done_w[1]), .count(cnt_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: differing bit indices in ascending order, truncated to the hit limit.
    task automatic model_push(input logic [31:0] a, input logic [31:0] b, output int n0, output int n1);
        int n [2];
        for (int k = 0; k < 2; k++) begin
            n[k] = 0;
            for (int i = 0; i < 32; i++) begin
                if (a[i] != b[i] && n[k] < mh[k]) begin
                    if (k == 0) exp_pos_q0.push_back(i);
                    else        exp_pos_q1.push_back(i);
                    n[k]++;
                end
            end
            if (k == 0) exp_cnt_q0.push_back(n[k]);
            else        exp_cnt_q1.push_back(n[k]);
        end
        n0 = n[0];
        n1 = n[1];
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            held = 2'b00;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (pv_w[k]) begin
                    if (held[k]) check($sformatf("pos_stable%0d", k), pos_w[k], held_pos[k]);
                    if (pos_ready) begin
                        held[k] = 1'b0;
                        if (k == 0 && exp_pos_q0.size() > 0)
                            check("pos0", pos_w[0], exp_pos_q0.pop_front());
                        else if (k == 1 && exp_pos_q1.size() > 0)
                            check("pos1", pos_w[1], exp_pos_q1.pop_front());
                        else
                            check($sformatf("extra_beat%0d", k), pos_w[k], -1);
                    end else begin
                        held[k] = 1'b1;
                        held_pos[k] = pos_w[k];
                    end
                end
                if (done_w[k]) begin
                    if (k == 0 && exp_cnt_q0.size() > 0)
                        check("count0", cnt_w[0], exp_cnt_q0.pop_front());
                    else if (k == 1 && exp_cnt_q1.size() > 0)
                        check("count1", cnt_w[1], exp_cnt_q1.pop_front());
                    else
                        check($sformatf("extra_done%0d", k), cnt_w[k], -1);
                end
            end
        end
    end

    // stall: 0 = ready held high, >0 = ready low that many cycles per beat, <0 = random ready.
    // inj: pulse start with fresh operands mid-scan (must be ignored).
    task automatic do_scan(input logic [31:0] a, input logic [31:0] b, input int stall, input bit inj);
        int n0, n1, edges, wait_cnt;
        int done_edge [2];
        int done_cyc [2];
        model_push(a, b, n0, n1);
        a_in = a;
        b_in = b;
        start = 1'b1;
        pos_ready = (stall == 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in = $urandom;
        b_in = $urandom;
        check("busy_after_start", busy_w, 2'b11);
        edges = 0;
        wait_cnt = 0;
        done_edge[0] = -1;
        done_edge[1] = -1;
        done_cyc[0] = 0;
        done_cyc[1] = 0;
        while (busy_w != 2'b00 && edges < 3000) begin
            if (stall == 0) begin
                pos_ready = 1'b1;
            end else if (stall > 0) begin
                pos_ready = pv_w[0] && (wait_cnt == stall);
                if (pv_w[0] && wait_cnt < stall) wait_cnt++;
                else wait_cnt = 0;
            end else begin
                pos_ready = ($urandom_range(0, 9) < 7);
            end
            start = inj && (edges == 3) && (busy_w == 2'b11);
            @(posedge clk);
            #1;
            start = 1'b0;
            edges++;
            for (int k = 0; k < 2; k++) begin
                if (done_w[k]) begin
                    done_cyc[k]++;
                    if (done_edge[k] < 0) done_edge[k] = edges;
                end
            end
        end
        if (edges >= 3000) check("scan_timeout", edges, -1);
        check("done_pulses0", done_cyc[0], 1);
        check("done_pulses1", done_cyc[1], 1);
        if (stall == 0) begin
            check("done_latency0", done_edge[0], 1 + 2 * n0);
            check("done_latency1", done_edge[1], 1 + 2 * n1);
        end
        pos_ready = 1'b0;
    endtask

    initial begin
        int n0, n1, guard;
        logic [31:0] ra, rmask;
        n_chk = 0;
        n_pass = 0;
        mh[0] = 32;
        mh[1] = 4;
        held = 2'b00;
        rst = 1'b1;
        start = 1'b0;
        a_in = '0;
        b_in = '0;
        pos_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy_w, 0);
        check("rst_valid", pv_w, 0);
        check("rst_done", done_w, 0);
        check("rst_pos0", pos_w[0], 0);
        check("rst_count0", cnt_w[0], 0);
        check("rst_count1", cnt_w[1], 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        do_scan(32'hFFFFFFFF, 32'hFFFFFEFF, 0, 1'b0);
        check("count_hold_idle", cnt_w[0], 1);
        do_scan(32'hFFFF7EFF, 32'hFFFFFEFF, 0, 1'b0);
        do_scan(32'h00000000, 32'h00000000, 0, 1'b0);
        do_scan(32'h00000000, 32'h80000001, 5, 1'b0);
        do_scan(32'h00000000, 32'hFFFFFFFF, 0, 1'b0);
        do_scan(32'h00000000, 32'h0000F0F0, 0, 1'b1);
        do_scan(32'h12345678, 32'h12345678 ^ 32'h00810042, -1, 1'b1);

        // start held during FIN only: must not launch a new scan
        model_push(32'h0, 32'h1, n0, n1);
        a_in = 32'h0;
        b_in = 32'h1;
        start = 1'b1;
        pos_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        guard = 0;
        while (!done_w[0] && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("fin_reached", done_w[0], 1);
        a_in = 32'hDEADBEEF;
        b_in = 32'h0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("fin_start_ignored", busy_w, 0);
        repeat (3) @(posedge clk);
        #1;
        check("fin_start_still_idle", busy_w, 0);

        // reset while a beat is stalled in EMIT
        model_push(32'h0, 32'hFFFFFFFF, n0, n1);
        a_in = 32'h0;
        b_in = 32'hFFFFFFFF;
        start = 1'b1;
        pos_ready = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        guard = 0;
        while (!pv_w[0] && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("emit_reached", pv_w, 2'b11);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_valid", pv_w, 0);
        check("abort_busy", busy_w, 0);
        check("abort_count0", cnt_w[0], 0);
        check("abort_pos0", pos_w[0], 0);
        exp_pos_q0.delete();
        exp_pos_q1.delete();
        exp_cnt_q0.delete();
        exp_cnt_q1.delete();
        rst = 1'b0;
        @(posedge clk);
        #1;
        ra = $urandom;
        do_scan(ra, ra, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rmask = 32'h0;
                1: rmask = 32'h1 << $urandom_range(0, 31);
                2: rmask = $urandom & $urandom & $urandom;
                default: rmask = $urandom;
            endcase
            do_scan(ra, ra ^ rmask, (t % 3 == 0) ? 0 : -1, (t % 5 == 0));
        end

        repeat (2) @(posedge clk);
        #1;
        check("leftover_pos0", exp_pos_q0.size(), 0);
        check("leftover_pos1", exp_pos_q1.size(), 0);
        check("leftover_cnt0", exp_cnt_q0.size(), 0);
        check("leftover_cnt1", exp_cnt_q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
